// File: rtl/regfile_mp.sv
// Multi-read-port register file with optional zero register and a sequenced soft-clear engine.
// Latency: combinational reads, writes commit at the clk edge; clear walks one entry per cycle (DEPTH cycles busy, then a 1-cycle done pulse).
// Backpressure: none; writes arriving while clearing, out of range, or to the zero register are dropped and flagged on wr_drop.
// Optional feature: define REGFILE_MP_BYPASS_EN for same-cycle write-through forwarding to the read ports.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 64,
    parameter int ADDR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int N_RD     = 2,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_RD*ADDR_W-1:0]   ra,
    output logic [N_RD*DATA_W-1:0]   rd,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wa,
    input  logic [DATA_W-1:0]        wd,
    input  logic                     clr_req,
    output logic                     clr_busy,
    output logic                     clr_done,
    output logic                     wr_drop
);

    localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LP_LAST  = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] LP_ONE   = (ADDR_W+1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t              r_state;
    logic [ADDR_W:0]     r_idx;
    logic                r_busy;
    logic                r_done;
    logic                r_drop;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                w_wa_ok;
    logic                w_wr_ok;

    assign w_wa_ok = ({1'b0, wa} < LP_DEPTH) && !(ZERO_REG && (wa == '0));
    assign w_wr_ok = we && (r_state == ST_IDLE) && w_wa_ok;

    // The index is one bit wider than the address so DEPTH == 2**ADDR_W cannot wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_drop  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_drop <= we && !w_wr_ok;
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_wr_ok) begin
                        r_mem[wa] <= wd;
                    end
                    if (clr_req) begin
                        r_state <= ST_CLEAR;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    r_mem[r_idx[ADDR_W-1:0]] <= '0;
                    r_idx <= r_idx + LP_ONE;
                    if (r_idx == LP_LAST) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign clr_busy = r_busy;
    assign clr_done = r_done;
    assign wr_drop  = r_drop;

    for (genvar gi = 0; gi < N_RD; gi++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        logic              w_ra_ok;
        logic [DATA_W-1:0] w_rd;

        assign w_ra    = ra[gi*ADDR_W +: ADDR_W];
        assign w_ra_ok = ({1'b0, w_ra} < LP_DEPTH) && !(ZERO_REG && (w_ra == '0));

        always_comb begin
            w_rd = '0;
            if (w_ra_ok) begin
                w_rd = r_mem[w_ra];
            end
`ifdef REGFILE_MP_BYPASS_EN
            if (w_wr_ok && (wa == w_ra)) begin
                w_rd = wd;
            end
`endif
        end

        assign rd[gi*DATA_W +: DATA_W] = w_rd;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: reset, write/read, drops, clear sequencing, async reset mid-clear.
module tb_regfile_mp;

    localparam int DW = 32;
    localparam int AW = 6;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [2*AW-1:0] ra, ra_b;
    logic [2*DW-1:0] rd, rd_b;
    logic            we, we_b;
    logic [AW-1:0]   wa, wa_b;
    logic [DW-1:0]   wd, wd_b;
    logic            clr_req, clr_req_b;
    logic            clr_busy, clr_busy_b;
    logic            clr_done, clr_done_b;
    logic            wr_drop, wr_drop_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(DW), .DEPTH(64), .N_RD(2), .ZERO_REG(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .ra(ra), .rd(rd), .we(we), .wa(wa), .wd(wd),
        .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done), .wr_drop(wr_drop)
    );

    regfile_mp #(.DATA_W(DW), .DEPTH(48), .N_RD(2), .ZERO_REG(1'b1)) u_dut48 (
        .clk(clk), .rst_n(rst_n), .ra(ra_b), .rd(rd_b), .we(we_b), .wa(wa_b), .wd(wd_b),
        .clr_req(clr_req_b), .clr_busy(clr_busy_b), .clr_done(clr_done_b), .wr_drop(wr_drop_b)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int addr, input logic [DW-1:0] data);
        we = 1'b1;
        wa = AW'(addr);
        wd = data;
        tick();
        we = 1'b0;
    endtask

    initial begin
        int busy_cnt;
        int done_cyc;
        logic [DW-1:0] exp_same;

        rst_n = 1'b1;
        ra = '0; we = 1'b0; wa = '0; wd = '0; clr_req = 1'b0;
        ra_b = '0; we_b = 1'b0; wa_b = '0; wd_b = '0; clr_req_b = 1'b0;
        #1 rst_n = 1'b0;
        #5;
        check("rst_busy", 64'(clr_busy), 64'(0));
        check("rst_done", 64'(clr_done), 64'(0));
        check("rst_drop", 64'(wr_drop), 64'(0));
        #6 rst_n = 1'b1;
        tick();

        // 1: every address on both ports reads zero after reset
        for (int a = 0; a < 64; a++) begin
            ra = {AW'(63 - a), AW'(a)};
            #1;
            check("t1_rd0", 64'(rd[DW-1:0]), 64'(0));
            check("t1_rd1", 64'(rd[2*DW-1:DW]), 64'(0));
        end
        check("t1_busy", 64'(clr_busy), 64'(0));
        tick();

        // 2: basic write then dual-port read of the same entry
        we = 1'b1; wa = 6'd5; wd = 32'hDEADBEEF; ra = {6'd5, 6'd5};
        #2;
`ifdef REGFILE_MP_BYPASS_EN
        exp_same = 32'hDEADBEEF;
`else
        exp_same = 32'h0;
`endif
        check("t2_same_cycle", 64'(rd[DW-1:0]), 64'(exp_same));
        tick();
        we = 1'b0;
        check("t2_rd0", 64'(rd[DW-1:0]), 64'(32'hDEADBEEF));
        check("t2_rd1", 64'(rd[2*DW-1:DW]), 64'(32'hDEADBEEF));
        check("t2_nodrop", 64'(wr_drop), 64'(0));

        // 3: zero-register write is dropped and never forwarded
        we = 1'b1; wa = 6'd0; wd = 32'h1234; ra = {6'd5, 6'd0};
        #2;
        check("t3_zero_same", 64'(rd[DW-1:0]), 64'(0));
        tick();
        we = 1'b0;
        check("t3_zero_drop", 64'(wr_drop), 64'(1));
        check("t3_zero_rd", 64'(rd[DW-1:0]), 64'(0));
        check("t3_other_rd", 64'(rd[2*DW-1:DW]), 64'(32'hDEADBEEF));
        tick();
        check("t3_drop_pulse", 64'(wr_drop), 64'(0));

        // 3b: DEPTH=48 instance, write at wa==DEPTH is dropped
        we_b = 1'b1; wa_b = 6'd47; wd_b = 32'h47;
        tick();
        we_b = 1'b0;
        check("t3b_last_ok", 64'(wr_drop_b), 64'(0));
        we_b = 1'b1; wa_b = 6'd48; wd_b = 32'h48; ra_b = {6'd48, 6'd47};
        tick();
        we_b = 1'b0;
        check("t3b_oor_drop", 64'(wr_drop_b), 64'(1));
        check("t3b_last_rd", 64'(rd_b[DW-1:0]), 64'(32'h47));
        check("t3b_oor_rd", 64'(rd_b[2*DW-1:DW]), 64'(0));
        tick();
        check("t3b_drop_pulse", 64'(wr_drop_b), 64'(0));

        // 4: fill, clear, mid-clear dropped write
        for (int a = 1; a < 64; a++) wr(a, DW'(a));
        ra = {6'd63, 6'd10};
        #1;
        check("t4_fill10", 64'(rd[DW-1:0]), 64'(10));
        check("t4_fill63", 64'(rd[2*DW-1:DW]), 64'(63));
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        busy_cnt = 0;
        done_cyc = 0;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            if (clr_busy) busy_cnt++;
            if (clr_done) begin
                done_cyc = cyc;
                break;
            end
            if (cyc == 11) check("t4_midclr_drop", 64'(wr_drop), 64'(1));
            if (cyc == 10) begin
                ra = {6'd40, 6'd3};
                we = 1'b1; wa = 6'd3; wd = 32'hFF;
                #1;
                check("t4_mid_cleared", 64'(rd[DW-1:0]), 64'(0));
                check("t4_mid_intact", 64'(rd[2*DW-1:DW]), 64'(40));
            end
            tick();
            we = 1'b0;
        end
        check("t4_busy_cycles", 64'(busy_cnt), 64'(64));
        check("t4_done_cycle", 64'(done_cyc), 64'(65));
        tick();
        check("t4_done_pulse", 64'(clr_done), 64'(0));
        check("t4_busy_after", 64'(clr_busy), 64'(0));
        for (int a = 0; a < 64; a++) begin
            ra = {AW'(63 - a), AW'(a)};
            #1;
            check("t4_clr_rd0", 64'(rd[DW-1:0]), 64'(0));
            check("t4_clr_rd1", 64'(rd[2*DW-1:DW]), 64'(0));
        end
        tick();

        // 5: write and clr_req on the same edge; clr_req held to force a restart
        we = 1'b1; wa = 6'd7; wd = 32'hA5; clr_req = 1'b1; ra = {6'd7, 6'd7};
        tick();
        we = 1'b0;
        busy_cnt = 0;
        done_cyc = 0;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            if (clr_busy) busy_cnt++;
            if (clr_done) begin
                done_cyc = cyc;
                break;
            end
            if (cyc == 1) check("t5_committed", 64'(rd[DW-1:0]), 64'(32'hA5));
            if (cyc == 8) check("t5_before_idx", 64'(rd[DW-1:0]), 64'(32'hA5));
            if (cyc == 9) check("t5_after_idx", 64'(rd[DW-1:0]), 64'(0));
            tick();
        end
        check("t5_busy_cycles", 64'(busy_cnt), 64'(64));
        check("t5_done_cycle", 64'(done_cyc), 64'(65));
        tick();
        check("t5_idle_busy", 64'(clr_busy), 64'(0));
        check("t5_idle_done", 64'(clr_done), 64'(0));
        tick();
        check("t5_restart", 64'(clr_busy), 64'(1));
        clr_req = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (clr_done) break;
            tick();
        end
        check("t5_second_done", 64'(clr_done), 64'(1));
        tick();

        // 6: asynchronous reset in the middle of a clear
        wr(30, 32'h30);
        wr(50, 32'h50);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int c = 1; c < 21; c++) tick();
        ra = {6'd50, 6'd30};
        #1;
        check("t6_busy_mid", 64'(clr_busy), 64'(1));
        check("t6_pre_rst30", 64'(rd[DW-1:0]), 64'(32'h30));
        #1 rst_n = 1'b0;
        #1;
        check("t6_rst_busy", 64'(clr_busy), 64'(0));
        check("t6_rst_done", 64'(clr_done), 64'(0));
        check("t6_rst_rd30", 64'(rd[DW-1:0]), 64'(0));
        check("t6_rst_rd50", 64'(rd[2*DW-1:DW]), 64'(0));
        #2 rst_n = 1'b1;
        we = 1'b1; wa = 6'd9; wd = 32'h99; ra = {6'd9, 6'd9};
        tick();
        we = 1'b0;
        check("t6_post_wr", 64'(rd[DW-1:0]), 64'(32'h99));
        check("t6_post_drop", 64'(wr_drop), 64'(0));
        check("t6_post_busy", 64'(clr_busy), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
